// File: rtl/grid_step_ctrl_if.sv
// Bus between the grid step controller and its requester / tile-map.
// slave = controller side, master = requester and tile-map side.
interface grid_step_ctrl_if #(
    parameter int GRID_W = 16,
    parameter int GRID_H = 8
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    logic          move_valid;
    logic [1:0]    move_dir;
    logic          move_ready;
    logic          map_rd_en;
    logic [XW-1:0] map_rd_x;
    logic [YW-1:0] map_rd_y;
    logic          map_blocked;
    logic [XW-1:0] grid_x;
    logic [YW-1:0] grid_y;
    logic [1:0]    dir;
    logic [XW-1:0] x_front;
    logic [YW-1:0] y_front;
    logic          front_valid;
    logic          moved;
    logic          turned;
    logic          blocked;

    modport master (
        output move_valid, move_dir, map_blocked,
        input  move_ready, map_rd_en, map_rd_x, map_rd_y,
               grid_x, grid_y, dir, x_front, y_front, front_valid,
               moved, turned, blocked
    );

    modport slave (
        input  move_valid, move_dir, map_blocked,
        output move_ready, map_rd_en, map_rd_x, map_rd_y,
               grid_x, grid_y, dir, x_front, y_front, front_valid,
               moved, turned, blocked
    );
endinterface

// File: rtl/grid_step_ctrl.sv
// Grid step controller: turns on a direction change, otherwise checks the
// tile in front against the tile-map and steps into it if passable.
//
// state      | meaning
// S_IDLE     | ready for a move request
// S_LOOKUP   | tile-map read of the front tile issued
// S_CHECK    | tile-map response sampled, move or block decided
// S_COOLDOWN | down-counter holding off new requests after a move/turn
module grid_step_ctrl #(
    parameter int         GRID_W    = 16,
    parameter int         GRID_H    = 8,
    parameter int         COOLDOWN  = 4,
    parameter int         START_X   = 0,
    parameter int         START_Y   = 0,
    parameter logic [1:0] START_DIR = 2'd1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    grid_step_ctrl_if.slave  bus
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(GRID_H - 1);
    localparam logic [XW-1:0] X_RST   = XW'(START_X);
    localparam logic [YW-1:0] Y_RST   = YW'(START_Y);
    localparam logic [15:0]   CD_LOAD = 16'(COOLDOWN);

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_CHECK,
        S_COOLDOWN
    } state_t;

    state_t        r_state,   w_state_nxt;
    logic [XW-1:0] r_grid_x,  w_grid_x_nxt;
    logic [YW-1:0] r_grid_y,  w_grid_y_nxt;
    logic [1:0]    r_dir,     w_dir_nxt;
    logic [15:0]   r_cnt,     w_cnt_nxt;
    logic          r_moved,   w_moved_nxt;
    logic          r_turned,  w_turned_nxt;
    logic          r_blocked, w_blocked_nxt;

    logic [XW-1:0] w_x_front;
    logic [YW-1:0] w_y_front;
    logic          w_front_valid;
    logic          w_handshake;
    logic          w_rd_en;

    // Front tile saturates at the grid edge instead of wrapping.
    always_comb begin
        w_x_front     = r_grid_x;
        w_y_front     = r_grid_y;
        w_front_valid = 1'b0;
        case (r_dir)
            DIR_LEFT: if (r_grid_x != '0) begin
                w_x_front     = r_grid_x - XW'(1);
                w_front_valid = 1'b1;
            end
            DIR_RIGHT: if (r_grid_x != X_MAX) begin
                w_x_front     = r_grid_x + XW'(1);
                w_front_valid = 1'b1;
            end
            DIR_UP: if (r_grid_y != '0) begin
                w_y_front     = r_grid_y - YW'(1);
                w_front_valid = 1'b1;
            end
            DIR_DOWN: if (r_grid_y != Y_MAX) begin
                w_y_front     = r_grid_y + YW'(1);
                w_front_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_handshake = bus.move_valid && (r_state == S_IDLE);

    always_comb begin
        w_state_nxt   = r_state;
        w_grid_x_nxt  = r_grid_x;
        w_grid_y_nxt  = r_grid_y;
        w_dir_nxt     = r_dir;
        w_cnt_nxt     = r_cnt;
        w_moved_nxt   = 1'b0;
        w_turned_nxt  = 1'b0;
        w_blocked_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_handshake) begin
                    if (bus.move_dir != r_dir) begin
                        w_dir_nxt    = bus.move_dir;
                        w_turned_nxt = 1'b1;
                        w_cnt_nxt    = CD_LOAD;
                        w_state_nxt  = S_COOLDOWN;
                    end else if (!w_front_valid) begin
                        w_blocked_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (bus.map_blocked) begin
                    w_blocked_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_grid_x_nxt = w_x_front;
                    w_grid_y_nxt = w_y_front;
                    w_moved_nxt  = 1'b1;
                    w_cnt_nxt    = CD_LOAD;
                    w_state_nxt  = S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                w_cnt_nxt = r_cnt - 16'd1;
                if (r_cnt <= 16'd1) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state   <= S_IDLE;
            r_grid_x  <= X_RST;
            r_grid_y  <= Y_RST;
            r_dir     <= START_DIR;
            r_cnt     <= '0;
            r_moved   <= 1'b0;
            r_turned  <= 1'b0;
            r_blocked <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grid_x  <= w_grid_x_nxt;
            r_grid_y  <= w_grid_y_nxt;
            r_dir     <= w_dir_nxt;
            r_cnt     <= w_cnt_nxt;
            r_moved   <= w_moved_nxt;
            r_turned  <= w_turned_nxt;
            r_blocked <= w_blocked_nxt;
        end
    end

    // Position is frozen during LOOKUP, so the front tile is the read address.
    assign w_rd_en          = (r_state == S_LOOKUP);
    assign bus.map_rd_en    = w_rd_en;
    assign bus.map_rd_x     = w_rd_en ? w_x_front : '0;
    assign bus.map_rd_y     = w_rd_en ? w_y_front : '0;
    assign bus.move_ready   = (r_state == S_IDLE);
    assign bus.grid_x       = r_grid_x;
    assign bus.grid_y       = r_grid_y;
    assign bus.dir          = r_dir;
    assign bus.x_front      = w_x_front;
    assign bus.y_front      = w_y_front;
    assign bus.front_valid  = w_front_valid;
    assign bus.moved        = r_moved;
    assign bus.turned       = r_turned;
    assign bus.blocked      = r_blocked;
endmodule

// File: tb/tb_grid_step_ctrl.sv
// Directed bench for grid_step_ctrl at default parameters (16x8, cooldown 4,
// start (0,0) facing RIGHT); expected values are hand-computed constants.
module tb_grid_step_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    grid_step_ctrl_if #(.GRID_W(16), .GRID_H(8)) bus ();

    grid_step_ctrl dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake(input string tag, input logic [1:0] d);
        chk({tag, " ready before"}, 32'(bus.move_ready), 1);
        bus.move_valid = 1'b1;
        bus.move_dir   = d;
        step();
        bus.move_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int max_cycles);
        int n = 0;
        while (!bus.move_ready && n < max_cycles) begin
            step();
            n++;
        end
        if (!bus.move_ready) chk({tag, " ready timeout"}, 0, 1);
    endtask

    initial begin
        int n, moves, rds, multi;
        rst_n           = 1'b0;
        bus.move_valid  = 1'b0;
        bus.move_dir    = 2'd0;
        bus.map_blocked = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        chk("rst ready",   32'(bus.move_ready), 1);
        chk("rst grid_x",  32'(bus.grid_x), 0);
        chk("rst grid_y",  32'(bus.grid_y), 0);
        chk("rst dir",     32'(bus.dir), 1);
        chk("rst rd_en",   32'(bus.map_rd_en), 0);
        chk("rst pulses",  32'({bus.moved, bus.turned, bus.blocked}), 0);
        chk("rst x_front", 32'(bus.x_front), 1);
        chk("rst fv",      32'(bus.front_valid), 1);

        // Turn LEFT at x=0: front is off-grid.
        handshake("turnL", 2'd0);
        chk("turnL turned", 32'(bus.turned), 1);
        chk("turnL dir",    32'(bus.dir), 0);
        chk("turnL fv",     32'(bus.front_valid), 0);
        chk("turnL xf",     32'(bus.x_front), 0);
        chk("turnL gx",     32'(bus.grid_x), 0);
        chk("turnL ready",  32'(bus.move_ready), 0);
        step();
        chk("turnL pulse1", 32'(bus.turned), 0);
        step();
        step();
        chk("turnL cd last", 32'(bus.move_ready), 0);
        step();
        chk("turnL cd end",  32'(bus.move_ready), 1);

        handshake("edgeL", 2'd0);
        chk("edgeL blocked", 32'(bus.blocked), 1);
        chk("edgeL rd_en",   32'(bus.map_rd_en), 0);
        chk("edgeL ready",   32'(bus.move_ready), 1);
        step();
        chk("edgeL rd_en2",  32'(bus.map_rd_en), 0);
        chk("edgeL pulse",   32'(bus.blocked), 0);

        handshake("turnR", 2'd1);
        chk("turnR turned", 32'(bus.turned), 1);
        chk("turnR dir",    32'(bus.dir), 1);
        wait_ready("turnR", 10);

        // RIGHT into a blocked tile.
        handshake("mapblk", 2'd1);
        chk("mapblk rd_en", 32'(bus.map_rd_en), 1);
        bus.map_blocked = 1'b1;
        step();
        chk("mapblk rd_en off", 32'(bus.map_rd_en), 0);
        step();
        bus.map_blocked = 1'b0;
        chk("mapblk blocked", 32'(bus.blocked), 1);
        chk("mapblk moved",   32'(bus.moved), 0);
        chk("mapblk gx",      32'(bus.grid_x), 0);
        chk("mapblk ready",   32'(bus.move_ready), 1);

        // RIGHT into a free tile.
        handshake("move", 2'd1);
        chk("move rd_en",  32'(bus.map_rd_en), 1);
        chk("move rd_x",   32'(bus.map_rd_x), 1);
        chk("move rd_y",   32'(bus.map_rd_y), 0);
        chk("move ready1", 32'(bus.move_ready), 0);
        step();
        chk("move rd_en2", 32'(bus.map_rd_en), 0);
        chk("move rd_x2",  32'(bus.map_rd_x), 0);
        step();
        chk("move moved",  32'(bus.moved), 1);
        chk("move gx",     32'(bus.grid_x), 1);
        chk("move ready3", 32'(bus.move_ready), 0);
        for (int k = 4; k <= 6; k++) begin
            step();
            chk("move cd ready", 32'(bus.move_ready), 0);
        end
        step();
        chk("move ready7", 32'(bus.move_ready), 1);

        // Hold move_valid high: one move per 7-cycle period, x 1 -> 15.
        bus.move_valid = 1'b1;
        bus.move_dir   = 2'd1;
        n = 0; moves = 0; rds = 0; multi = 0;
        while (bus.grid_x != 4'd15 && n < 200) begin
            step();
            n++;
            if (bus.moved) moves++;
            if (bus.map_rd_en) rds++;
            if (32'(bus.moved) + 32'(bus.turned) + 32'(bus.blocked) > 1) multi++;
        end
        bus.move_valid = 1'b0;
        chk("walk cycles", 32'(n), 94);
        chk("walk moves",  32'(moves), 14);
        chk("walk reads",  32'(rds), 14);
        chk("walk onehot", 32'(multi), 0);
        chk("edgeR fv",    32'(bus.front_valid), 0);
        chk("edgeR xf",    32'(bus.x_front), 15);
        wait_ready("walk", 10);

        handshake("edgeR", 2'd1);
        chk("edgeR blocked", 32'(bus.blocked), 1);
        chk("edgeR rd_en",   32'(bus.map_rd_en), 0);
        chk("edgeR gx",      32'(bus.grid_x), 15);
        step();
        chk("edgeR gx2",     32'(bus.grid_x), 15);

        handshake("turnD", 2'd3);
        chk("turnD yf", 32'(bus.y_front), 1);
        chk("turnD xf", 32'(bus.x_front), 15);
        chk("turnD fv", 32'(bus.front_valid), 1);
        wait_ready("turnD", 10);

        // Reset while in CHECK; a late map response must be ignored.
        handshake("rstchk", 2'd3);
        chk("rstchk rd_x", 32'(bus.map_rd_x), 15);
        chk("rstchk rd_y", 32'(bus.map_rd_y), 1);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.map_blocked = 1'b1;
        chk("rstchk moved", 32'(bus.moved), 0);
        chk("rstchk ready", 32'(bus.move_ready), 1);
        chk("rstchk gx",    32'(bus.grid_x), 0);
        chk("rstchk gy",    32'(bus.grid_y), 0);
        chk("rstchk dir",   32'(bus.dir), 1);
        step();
        bus.map_blocked = 1'b0;
        chk("rstchk late blk", 32'(bus.blocked), 0);
        chk("rstchk ready2",   32'(bus.move_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
